// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Optional subtract mode is compiled in with `define SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_count;
  logic             r_carry;
  logic             r_cout;

  logic [WIDTH-1:0] w_b_load;
  logic             w_cin_load;
  logic             w_s;
  logic             w_c;
  logic             w_accept;
  logic             w_last;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert B and force the carry-in to 1.
  assign w_b_load   = sub ? ~b : b;
  assign w_cin_load = sub ? 1'b1 : cin;
`else
  assign w_b_load   = b;
  // sub has no effect in this build; masked so the port is still consumed.
  assign w_cin_load = cin | (sub & 1'b0);
`endif

  assign w_s      = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c      = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == SHIFT) && (r_count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = SHIFT;
      SHIFT:   if (r_count == LAST) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_load;
      r_carry <= w_cin_load;
      r_count <= '0;
    end else if (r_state == SHIFT) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_acc   <= {w_s, r_acc[WIDTH-1:1]};
      r_carry <= w_c;
      if (w_last) begin
        r_sum  <= {w_s, r_acc[WIDTH-1:1]};
        r_cout <= w_c;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8); honours SERIAL_ADDER_SUB_EN.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int checks;
  int failures;
  int cycles;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait out SHIFT (bounded), then verify busy length, done pulse and result.
  task automatic finish_op(input string tag, input logic [7:0] es, input logic ec);
    cycles = 0;
    while (busy === 1'b1 && cycles < 20) begin
      cycles++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, cycles, 8);
    chk({tag, "_done"}, {31'd0, done}, 1);
    chk({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    $display("op %s: sum=%02h cout=%0b (expected %02h/%0b)", tag, sum, cout, es, ec);
    @(negedge clk);
    chk({tag, "_done_drop"}, {31'd0, done}, 0);
  endtask

  task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic icin, input logic isub,
                        input logic [7:0] es, input logic ec, input logic [7:0] prev);
    a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs after acceptance; result must not depend on them.
    a = ~ia; b = 8'h3C; cin = ~icin; sub = ~isub;
    chk({tag, "_sum_held"}, {24'd0, sum}, {24'd0, prev});
    finish_op(tag, es, ec);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_sum", {24'd0, sum}, 0);
    chk("rst_cout", {31'd0, cout}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 0);

    run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 8'h00);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 8'h10);
    run_op("add_a5_5a_c", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
    run_op("add_9c_37", 8'h9C, 8'h37, 1'b0, 1'b0, 8'hD3, 1'b0, 8'h00);

    // start held high: second op only begins after DONE->IDLE.
    a = 8'h30; b = 8'h12; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h01; b = 8'h02;
    finish_op("hold_first", 8'h42, 1'b0);
    chk("hold_idle_gap", {31'd0, busy}, 0);
    @(negedge clk);
    chk("hold_second_busy", {31'd0, busy}, 1);
    start = 1'b0;
    finish_op("hold_second", 8'h03, 1'b0);

    // Reset after four shift edges aborts the op.
    a = 8'h11; b = 8'h22; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_before", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_sum", {24'd0, sum}, 0);
    chk("abort_cout", {31'd0, cout}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) cycles++;
    end
    chk("abort_no_done", cycles, 0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 8'h00);
    run_op("sub_07_05", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 8'hFE);
`else
    run_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'h0C, 1'b0, 8'h00);
    run_op("sub_07_05_c", 8'h07, 8'h05, 1'b1, 1'b1, 8'h0D, 1'b0, 8'h0C);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
